// File: rtl/conv_seq_pkg.sv
// Shared types and defaults for the 1-D convolution sequencer.
package conv_seq_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int OADDR_W_DEF = 7;
  localparam int KLEN_W_DEF  = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    WR    = 3'd4,
    FIN   = 3'd5
  } state_t;

  // A job with no taps, no stride, or a filter longer than the ifmap has no valid window.
  function automatic logic cfg_invalid(input int unsigned k, input int unsigned s,
                                       input int unsigned l);
    return (k == 0) || (s == 0) || (k > l);
  endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// Memory-side bus of the sequencer: ifmap/filter reads, MAC strobes, output write.
interface conv_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int OADDR_W = 7
);
  logic               ifmap_rd_en;
  logic [ADDR_W-1:0]  ifmap_rd_adr;
  logic               filt_rd_en;
  logic [ADDR_W-1:0]  filt_rd_adr;
  logic               mac_clr;
  logic               mac_en;
  logic               out_wr_en;
  logic [OADDR_W-1:0] out_wr_adr;
  logic               stall;

  modport master (
    output ifmap_rd_en, ifmap_rd_adr, filt_rd_en, filt_rd_adr,
    output mac_clr, mac_en, out_wr_en, out_wr_adr,
    input  stall
  );

  modport slave (
    input  ifmap_rd_en, ifmap_rd_adr, filt_rd_en, filt_rd_adr,
    input  mac_clr, mac_en, out_wr_en, out_wr_adr,
    output stall
  );
endinterface

// File: rtl/conv_addr_gen.sv
// Latched job configuration plus window base (b), tap (k) and window index (w) counters.
module conv_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OADDR_W = OADDR_W_DEF,
  parameter int KLEN_W  = KLEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clr_k,
  input  logic               rd_step,
  input  logic               advance,
  input  logic [ADDR_W-1:0]  x_in,
  input  logic [ADDR_W-1:0]  y_in,
  input  logic [OADDR_W-1:0] z_in,
  input  logic [ADDR_W-1:0]  l_in,
  input  logic [KLEN_W-1:0]  k_in,
  input  logic [2:0]         s_in,
  output logic [ADDR_W-1:0]  ifmap_rd_adr,
  output logic [ADDR_W-1:0]  filt_rd_adr,
  output logic [OADDR_W-1:0] out_wr_adr,
  output logic               last_tap,
  output logic               last_win
);
  localparam int AW1 = ADDR_W + 1;

  logic [ADDR_W-1:0]  x_q, x_d, y_q, y_d, l_q, l_d, b_q, b_d;
  logic [OADDR_W-1:0] z_q, z_d, w_q, w_d;
  logic [KLEN_W-1:0]  klen_q, klen_d, k_q, k_d;
  logic [2:0]         s_q, s_d;
  logic [AW1-1:0]     end_sum;

  always_comb begin
    x_d = x_q; y_d = y_q; z_d = z_q; l_d = l_q;
    klen_d = klen_q; s_d = s_q;
    b_d = b_q; k_d = k_q; w_d = w_q;
    if (load) begin
      x_d = x_in; y_d = y_in; z_d = z_in; l_d = l_in;
      klen_d = k_in; s_d = s_in;
      b_d = '0; k_d = '0; w_d = '0;
    end else begin
      if (clr_k)        k_d = '0;
      else if (rd_step) k_d = k_q + 1'b1;
      if (advance) begin
        b_d = b_q + ADDR_W'(s_q);
        w_d = w_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q <= '0; y_q <= '0; z_q <= '0; l_q <= '0;
      klen_q <= '0; s_q <= '0;
      b_q <= '0; k_q <= '0; w_q <= '0;
    end else begin
      x_q <= x_d; y_q <= y_d; z_q <= z_d; l_q <= l_d;
      klen_q <= klen_d; s_q <= s_d;
      b_q <= b_d; k_q <= k_d; w_q <= w_d;
    end
  end

  // One extra bit so the next window's end cannot wrap past the ifmap length.
  assign end_sum      = {1'b0, b_q} + AW1'(s_q) + AW1'(klen_q);
  assign last_win     = end_sum > {1'b0, l_q};
  assign last_tap     = (k_q == klen_q - 1'b1);
  assign ifmap_rd_adr = x_q + b_q + ADDR_W'(k_q);
  assign filt_rd_adr  = y_q + ADDR_W'(k_q);
  assign out_wr_adr   = z_q + w_q;

endmodule

// File: rtl/conv_sequencer.sv
// Sequences ifmap/filter reads, MAC strobes and output writes for a strided 1-D convolution.
//   state | meaning
//   IDLE  | waiting for start
//   CLR   | clear accumulator for the next window
//   RD    | issue K tap reads
//   DRAIN | last MAC lands (1-cycle memory latency)
//   WR    | write window result, held while stalled
//   FIN   | done pulse (with cfg_err on a rejected job)
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int OADDR_W = OADDR_W_DEF,
  parameter int KLEN_W  = KLEN_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  x_adr,
  input  logic [ADDR_W-1:0]  y_adr,
  input  logic [OADDR_W-1:0] z_adr,
  input  logic [ADDR_W-1:0]  ifmap_len,
  input  logic [KLEN_W-1:0]  filt_len,
  input  logic [2:0]         stride,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  conv_sequencer_if.master   mem
);
  state_t state_q, state_d;
  logic   busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic   rd_en_q, rd_en_d, mac_clr_q, mac_clr_d, mac_en_q, mac_en_d;
  logic   load, clr_k, rd_step, advance, last_tap, last_win;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    clr_k     = 1'b0;
    rd_step   = 1'b0;
    advance   = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load = 1'b1;
        if (cfg_invalid(32'(filt_len), 32'(stride), 32'(ifmap_len))) begin
          state_d   = FIN;
          cfg_err_d = 1'b1;
        end else begin
          state_d = CLR;
        end
      end
      CLR: begin
        clr_k   = 1'b1;
        state_d = RD;
      end
      RD: begin
        rd_step = 1'b1;
        if (last_tap) state_d = DRAIN;
      end
      DRAIN: state_d = WR;
      WR: if (!mem.stall) begin
        if (last_win) begin
          state_d = FIN;
        end else begin
          advance = 1'b1;
          state_d = CLR;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == FIN);
    rd_en_d   = (state_d == RD);
    mac_clr_d = (state_d == CLR);
    mac_en_d  = rd_en_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      rd_en_q   <= 1'b0;
      mac_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      rd_en_q   <= rd_en_d;
      mac_clr_q <= mac_clr_d;
      mac_en_q  <= mac_en_d;
    end
  end

  conv_addr_gen #(
    .ADDR_W (ADDR_W),
    .OADDR_W(OADDR_W),
    .KLEN_W (KLEN_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .clr_k       (clr_k),
    .rd_step     (rd_step),
    .advance     (advance),
    .x_in        (x_adr),
    .y_in        (y_adr),
    .z_in        (z_adr),
    .l_in        (ifmap_len),
    .k_in        (filt_len),
    .s_in        (stride),
    .ifmap_rd_adr(mem.ifmap_rd_adr),
    .filt_rd_adr (mem.filt_rd_adr),
    .out_wr_adr  (mem.out_wr_adr),
    .last_tap    (last_tap),
    .last_win    (last_win)
  );

  assign busy            = busy_q;
  assign done            = done_q;
  assign cfg_err         = cfg_err_q;
  assign mem.ifmap_rd_en = rd_en_q;
  assign mem.filt_rd_en  = rd_en_q;
  assign mem.mac_clr     = mac_clr_q;
  assign mem.mac_en      = mac_en_q;
  assign mem.out_wr_en   = (state_q == WR) && !mem.stall;

endmodule
